// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU group and function select constants
package alu_pkg;

    localparam logic [1:0] ALU_GRP_ARITH = 2'b00;
    localparam logic [1:0] ALU_GRP_LOGIC = 2'b01;
    localparam logic [1:0] ALU_GRP_SHR   = 2'b10;
    localparam logic [1:0] ALU_GRP_SHL   = 2'b11;

    localparam logic [1:0] ARITH_B    = 2'b00;
    localparam logic [1:0] ARITH_NB   = 2'b01;
    localparam logic [1:0] ARITH_ZERO = 2'b10;
    localparam logic [1:0] ARITH_ONE  = 2'b11;

    localparam logic [1:0] LOGIC_AND  = 2'b00;
    localparam logic [1:0] LOGIC_OR   = 2'b01;
    localparam logic [1:0] LOGIC_XOR  = 2'b10;
    localparam logic [1:0] LOGIC_NOTA = 2'b11;

endpackage

// File: rtl/alu_1bit_core.sv
// rtl/alu_1bit_core.sv - combinational datapath of one ALU slice
module alu_1bit_core
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [3:0] sel,
    output logic       f,
    output logic       cout
);

    logic       y;
    logic [1:0] sum;
    logic       logic_f;

    always_comb begin
        y = b;
        case (sel[1:0])
            ARITH_B:    y = b;
            ARITH_NB:   y = ~b;
            ARITH_ZERO: y = 1'b0;
            ARITH_ONE:  y = 1'b1;
            default:    y = b;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, y} + {1'b0, cin};

    always_comb begin
        logic_f = 1'b0;
        case (sel[1:0])
            LOGIC_AND:  logic_f = a & b;
            LOGIC_OR:   logic_f = a | b;
            LOGIC_XOR:  logic_f = a ^ b;
            LOGIC_NOTA: logic_f = ~a;
            default:    logic_f = 1'b0;
        endcase
    end

    // Both shift groups are identical here; direction comes from inter-slice wiring.
    always_comb begin
        f    = 1'b0;
        cout = 1'b0;
        case (sel[3:2])
            ALU_GRP_ARITH: begin
                f    = sum[0];
                cout = sum[1];
            end
            ALU_GRP_LOGIC: begin
                f    = logic_f;
                cout = 1'b0;
            end
            ALU_GRP_SHR,
            ALU_GRP_SHL: begin
                f    = cin;
                cout = a;
            end
            default: begin
                f    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_1bit.sv
// rtl/alu_1bit.sv - single-bit ALU slice with registered result and carry
module alu_1bit
    import alu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [3:0] sel_i,
    output logic       f_o,
    output logic       cout_o
);

    logic f_c;
    logic cout_c;

    alu_1bit_core u_core (
        .a    (a_i),
        .b    (b_i),
        .cin  (cin_i),
        .sel  (sel_i),
        .f    (f_c),
        .cout (cout_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_o    <= 1'b0;
            cout_o <= 1'b0;
        end else begin
            f_o    <= f_c;
            cout_o <= cout_c;
        end
    end

endmodule

// File: tb/tb_alu_1bit.sv
// tb/tb_alu_1bit.sv - scoreboard bench for the single-bit ALU slice
module tb_alu_1bit;

    logic       clk_i;
    logic       rst_i;
    logic       a_i;
    logic       b_i;
    logic       cin_i;
    logic [3:0] sel_i;
    logic       f_o;
    logic       cout_o;

    int checks;
    int failures;

    logic [1:0] sb_q[$];
    logic [1:0] last_exp;

    alu_1bit dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .sel_i  (sel_i),
        .f_o    (f_o),
        .cout_o (cout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference result as {cout, f}
    function automatic logic [1:0] model(input logic a, input logic b,
                                         input logic c, input logic [3:0] s);
        int total;
        int yv;
        if (s[3]) return {a, c};
        if (s[2]) begin
            case (s[1:0])
                2'd0: return {1'b0, a & b};
                2'd1: return {1'b0, a | b};
                2'd2: return {1'b0, a ^ b};
                default: return {1'b0, ~a};
            endcase
        end
        case (s[1:0])
            2'd0: yv = int'(b);
            2'd1: yv = b ? 0 : 1;
            2'd2: yv = 0;
            default: yv = 1;
        endcase
        total = int'(a) + yv + int'(c);
        return total[1:0];
    endfunction

    task automatic check(input string tag, input logic [1:0] exp);
        checks++;
        assert ({cout_o, f_o} === exp)
        else begin
            failures++;
            $error("FAIL %s observed={cout,f}=%b expected=%b", tag, {cout_o, f_o}, exp);
        end
    endtask

    // Drive one op just after an edge, verify outputs hold mid-cycle, then compare after the next edge.
    task automatic step(input logic a, input logic b, input logic c,
                        input logic [3:0] s, input logic [1:0] exp, input string tag);
        logic [1:0] e;
        a_i = a; b_i = b; cin_i = c; sel_i = s;
        sb_q.push_back(exp);
        #2;
        check({tag, "_hold"}, last_exp);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=%b expected=entry", tag, {cout_o, f_o});
        end else begin
            e = sb_q.pop_front();
            check(tag, e);
            last_exp = e;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_exp = 2'b00;

        rst_i = 1'b1;
        a_i = 1'b1; b_i = 1'b1; cin_i = 1'b1; sel_i = 4'b0000;
        #1;
        check("reset_async", 2'b00);
        @(posedge clk_i);
        #1;
        check("reset_held_edge", 2'b00);
        rst_i = 1'b0;
        step(1, 1, 1, 4'b0000, 2'b11, "reset_release");

        step(0, 0, 0, 4'b0000, 2'b00, "add_c0");
        step(0, 0, 1, 4'b0000, 2'b01, "add_c1");
        step(0, 0, 0, 4'b0001, 2'b01, "addnb_c0");
        step(0, 0, 1, 4'b0001, 2'b10, "addnb_c1");
        step(0, 0, 1, 4'b0010, 2'b01, "inc_c1");
        step(0, 0, 1, 4'b0011, 2'b10, "addone_c1");

        // Outputs now carry cout=1; reset mid-cycle must clear them with no edge
        #2;
        rst_i = 1'b1;
        #1;
        check("reset_midop", 2'b00);
        @(posedge clk_i);
        #1;
        check("reset_midop_edge", 2'b00);
        rst_i = 1'b0;
        last_exp = 2'b00;

        step(1, 1, 0, 4'b0000, 2'b10, "add_11");
        step(1, 1, 0, 4'b0001, 2'b01, "addnb_11");
        step(1, 1, 0, 4'b0010, 2'b01, "inc_11");
        step(1, 1, 0, 4'b0011, 2'b10, "addone_11");

        step(1, 0, 1, 4'b0100, 2'b00, "and_10");
        step(1, 0, 1, 4'b0101, 2'b01, "or_10");
        step(1, 0, 1, 4'b0110, 2'b01, "xor_10");
        step(1, 0, 1, 4'b0111, 2'b00, "nota_10");
        step(1, 1, 1, 4'b0100, 2'b01, "and_11");
        step(1, 1, 1, 4'b0101, 2'b01, "or_11");
        step(1, 1, 1, 4'b0110, 2'b00, "xor_11");
        step(1, 1, 1, 4'b0111, 2'b00, "nota_11");
        step(0, 0, 1, 4'b0100, 2'b00, "and_00");
        step(0, 0, 1, 4'b0101, 2'b00, "or_00");
        step(0, 0, 1, 4'b0110, 2'b00, "xor_00");
        step(0, 0, 1, 4'b0111, 2'b01, "nota_00");

        step(1, 0, 0, 4'b1000, 2'b10, "shr_a1");
        step(1, 1, 0, 4'b1100, 2'b10, "shl_a1");
        step(1, 0, 0, 4'b1011, 2'b10, "shr11_a1");
        step(1, 1, 0, 4'b1111, 2'b10, "shl11_a1");
        step(0, 1, 1, 4'b1000, 2'b01, "shr_c1");
        step(0, 0, 1, 4'b1100, 2'b01, "shl_c1");
        step(0, 1, 1, 4'b1011, 2'b01, "shr11_c1");
        step(0, 0, 1, 4'b1111, 2'b01, "shl11_c1");

        for (int i = 0; i < 64; i++) begin
            logic ra, rb, rc;
            logic [3:0] rs;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rs = 4'($urandom_range(0, 15));
            step(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rand%0d_sel%b", i, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
